// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle EX-stage ALU. It executes the 5-bit ALU op code and shift
//   amount produced by the ALU control decoder. Shifts run iteratively, one
//   bit per cycle. When FAST_SHIFT_EN is defined, a barrel shifter finishes
//   every shift in one pass and every op has latency 1.
//
//   Configuration macro: FAST_SHIFT_EN (undefined by default: iterative shifter)
//
//   Ports
//     clk        in   1        clock, rising edge
//     rst        in   1        synchronous reset, active-high
//     in_valid   in   1        operation presented
//     in_ready   out  1        unit can accept an operation (IDLE and not in reset)
//     alu_ctrl   in   5        op code (0 sll .. 16 lui; 17-31 yield zero)
//     shamt      in   SHAMT_W  immediate shift amount (codes 0-2)
//     op_a       in   WIDTH    rs value; variable shift amount = op_a[SHAMT_W-1:0]
//     op_b       in   WIDTH    rt / immediate; the shifted operand
//     out_valid  out  1        result valid (registered)
//     out_ready  in   1        consumer accepts the result
//     result     out  WIDTH    operation result (registered)
//     ovf        out  1        signed overflow for add/sub (registered)
//     zero       out  1        result == 0 (registered)
//     dbg_state  out  2        current FSM state (0 IDLE, 1 EXEC, 2 DONE)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Input: the producer holds alu_ctrl/shamt/op_a/op_b stable while
//   in_valid=1 until in_ready is seen. Output: result/ovf/zero stay stable
//   while out_valid=1 and out_ready=0.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         alu_ctrl,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               ovf,
    output logic               zero,
    output logic [1:0]         dbg_state
);

    // One extra bit so the LUI count (WIDTH/2) always fits.
    localparam int K_W = SHAMT_W + 1;
    localparam logic [K_W-1:0] LUI_K = K_W'(WIDTH / 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [4:0]       code_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] w_q;      // working value of the iterative shifter
    logic [K_W-1:0]   k_q;      // remaining shift steps
`ifdef FAST_SHIFT_EN
    logic [K_W-1:0]   amt_q;    // full shift amount for the barrel shifter
`endif

    logic [K_W-1:0]   k_sel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    assign in_ready  = (state == IDLE) & ~rst;
    assign dbg_state = state;

    // Shift amount picked at accept time from the incoming op.
    always_comb begin
        k_sel = '0;
        case (alu_ctrl)
            5'd0, 5'd1, 5'd2: k_sel = {1'b0, shamt};
            5'd3, 5'd4, 5'd5: k_sel = {1'b0, op_a[SHAMT_W-1:0]};
            5'd16:            k_sel = LUI_K;
            default:          k_sel = '0;
        endcase
    end

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

`ifdef FAST_SHIFT_EN
    always_comb begin
        shift_val = b_q;
        case (code_q)
            5'd1, 5'd4: shift_val = b_q >> amt_q;
            5'd2, 5'd5: shift_val = $signed(b_q) >>> amt_q;
            default:    shift_val = b_q << amt_q;
        endcase
    end
`else
    // By the time k_q reaches 0 the working value holds the full shift.
    assign shift_val = w_q;
`endif

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (code_q)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd16: res_c = shift_val;
            5'd6: begin
                res_c = sum;
                // Overflow: operands share a sign and the sum's sign differs.
                ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            5'd7: res_c = sum;
            5'd8: begin
                res_c = diff;
                // Overflow: operand signs differ and the result's sign leaves op_a's.
                ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            5'd9:  res_c = diff;
            5'd10: res_c = a_q & b_q;
            5'd11: res_c = a_q | b_q;
            5'd12: res_c = a_q ^ b_q;
            5'd13: res_c = ~(a_q | b_q);
            5'd14: res_c = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            5'd15: res_c = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            code_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            w_q       <= '0;
            k_q       <= '0;
`ifdef FAST_SHIFT_EN
            amt_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q <= alu_ctrl;
                        a_q    <= op_a;
                        b_q    <= op_b;
                        w_q    <= op_b;
`ifdef FAST_SHIFT_EN
                        amt_q  <= k_sel;
                        k_q    <= '0;
`else
                        k_q    <= k_sel;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (k_q != '0) begin
                        case (code_q)
                            5'd1, 5'd4: w_q <= {1'b0, w_q[WIDTH-1:1]};
                            5'd2, 5'd5: w_q <= {w_q[WIDTH-1], w_q[WIDTH-1:1]};
                            default:    w_q <= {w_q[WIDTH-2:0], 1'b0};
                        endcase
                        k_q <= k_q - 1'b1;
                    end else begin
                        result    <= res_c;
                        ovf       <= ovf_c;
                        zero      <= (res_c == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_ctrl = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall = 0;
    logic hs_prev = 1'b0;

    logic [31:0] exp_q[$];
    logic        exp_ovf_q[$];
    int          due_q[$];

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .shamt(shamt), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected result, overflow and number of shift steps for one op.
    function automatic void model(input logic [4:0] op, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output int k);
        logic signed [31:0] bs;
        longint s;
        bs = b;
        r = 32'd0;
        o = 1'b0;
        k = 0;
        case (op)
            5'd0: begin r = b << sh;       k = sh;   end
            5'd1: begin r = b >> sh;       k = sh;   end
            5'd2: begin r = bs >>> sh;     k = sh;   end
            5'd3: begin r = b << a[4:0];   k = a[4:0]; end
            5'd4: begin r = b >> a[4:0];   k = a[4:0]; end
            5'd5: begin r = bs >>> a[4:0]; k = a[4:0]; end
            5'd6, 5'd7: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (op == 5'd6) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            5'd8, 5'd9: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (op == 5'd8) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            5'd10: r = a & b;
            5'd11: r = a | b;
            5'd12: r = a ^ b;
            5'd13: r = ~(a | b);
            5'd14: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd15: r = (a < b) ? 32'd1 : 32'd0;
            5'd16: begin r = b << 16; k = 16; end
            default: r = 32'd0;
        endcase
`ifdef FAST_SHIFT_EN
        k = 0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic send_op(input logic [4:0] op, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic o;
        int k;
        bit ok;
        @(negedge clk);
        alu_ctrl = op; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            model(op, sh, a, b, r, o, k);
            exp_q.push_back(r);
            exp_ovf_q.push_back(o);
            due_q.push_back(cyc + 2 + k);   // accept edge cyc+1, valid after edge +1+k
        end
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; alu_ctrl = 5'($urandom); shamt = 5'($urandom);
    endtask

    // ---------------- scoreboard / compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete(); exp_ovf_q.delete(); due_q.delete();
                hs_prev = 1'b0;
                out_ready = 1'b0;
                chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            end else begin
                if (hs_prev) begin
                    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                    chk("valid_drop_after_hs", {31'd0, out_valid}, 32'd0);
                    hs_prev = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk("idle_valid", {31'd0, out_valid}, 32'd0);
                    out_ready = 1'($urandom_range(0, 1));
                end else if (cyc < due_q[0]) begin
                    chk("early_valid", {31'd0, out_valid}, 32'd0);
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    chk("out_valid", {31'd0, out_valid}, 32'd1);
                    chk("result", result, exp_q[0]);
                    chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf_q[0]});
                    chk("zero", {31'd0, zero}, (exp_q[0] == 32'd0) ? 32'd1 : 32'd0);
                    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        stall--;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready && out_valid) begin
                        void'(exp_q.pop_front());
                        void'(exp_ovf_q.pop_front());
                        void'(due_q.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        logic o;
        int k;
        logic [4:0] op;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // Pin the model to hand-computed values.
        model(5'd6, 5'd0, 32'h7FFFFFFF, 32'd1, r, o, k);
        chk("m_add_res", r, 32'h80000000); chk("m_add_ovf", {31'd0, o}, 32'd1); chk("m_add_k", k, 0);
        model(5'd7, 5'd0, 32'h7FFFFFFF, 32'd1, r, o, k);
        chk("m_addu_ovf", {31'd0, o}, 32'd0);
        model(5'd8, 5'd0, 32'h80000000, 32'd1, r, o, k);
        chk("m_sub_res", r, 32'h7FFFFFFF); chk("m_sub_ovf", {31'd0, o}, 32'd1);
        model(5'd2, 5'd4, 32'd0, 32'h80000000, r, o, k);
        chk("m_sra_res", r, 32'hF8000000);
`ifdef FAST_SHIFT_EN
        chk("m_sra_k", k, 0);
`else
        chk("m_sra_k", k, 4);
`endif
        model(5'd4, 5'd0, 32'd31, 32'hFFFFFFFF, r, o, k);
        chk("m_srlv_res", r, 32'h00000001);
        model(5'd16, 5'd0, 32'd0, 32'h00001234, r, o, k);
        chk("m_lui_res", r, 32'h12340000);
        model(5'd14, 5'd0, 32'hFFFFFFFF, 32'd1, r, o, k);
        chk("m_slt_res", r, 32'd1);
        model(5'd15, 5'd0, 32'hFFFFFFFF, 32'd1, r, o, k);
        chk("m_sltu_res", r, 32'd0);
        model(5'd13, 5'd0, 32'h0F0F0000, 32'h000000F0, r, o, k);
        chk("m_nor_res", r, 32'hF0F0FF0F);
        model(5'd21, 5'd3, 32'h5, 32'h7, r, o, k);
        chk("m_undef_res", r, 32'd0); chk("m_undef_k", k, 0);

        // Directed ops through the DUT.
        send_op(5'd6, 5'd0, 32'h7FFFFFFF, 32'd1);
        send_op(5'd7, 5'd0, 32'h7FFFFFFF, 32'd1);
        send_op(5'd2, 5'd4, 32'd0, 32'h80000000);
        send_op(5'd4, 5'd0, 32'd31, 32'hFFFFFFFF);
        send_op(5'd16, 5'd0, 32'd0, 32'h00001234);
        send_op(5'd14, 5'd0, 32'hFFFFFFFF, 32'd1);
        send_op(5'd15, 5'd0, 32'hFFFFFFFF, 32'd1);
        send_op(5'd0, 5'd0, 32'd0, 32'hDEADBEEF);
        send_op(5'd3, 5'd0, 32'hFFFFFFE0, 32'h00000055);
        send_op(5'd25, 5'd9, 32'h1234, 32'h5678);
        stall = 5;
        send_op(5'd8, 5'd0, 32'd10, 32'd3);
        send_op(5'd9, 5'd0, 32'd3, 32'd10);

        // Reset in the middle of a 20-step sllv; the op must vanish.
        send_op(5'd3, 5'd0, 32'd20, 32'h00000001);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_state", {30'd0, dbg_state}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send_op(5'd6, 5'd0, 32'd2, 32'd3);
        model(5'd6, 5'd0, 32'd2, 32'd3, r, o, k);
        chk("m_add_2_3", r, 32'd5);

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 8) op = 5'($urandom_range(0, 16));
            else                          op = 5'($urandom_range(17, 31));
            if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0:       send_op(op, 5'($urandom), 32'h7FFFFFFF - 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                1:       send_op(op, 5'($urandom), 32'h80000000 + 32'($urandom_range(0, 3)), $urandom);
                default: send_op(op, 5'($urandom), $urandom, $urandom);
            endcase
        end

        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
